// File: rtl/serial_adder6_if.sv
// rtl/serial_adder6_if.sv - start/busy/done handshake and operand/result bus for the serial adder
interface serial_adder6_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/serial_adder6.sv
// rtl/serial_adder6.sv - bit-serial ripple adder, one full-adder cell time-multiplexed LSB first
module serial_adder6 #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 3
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder6_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] aSh;
  logic [WIDTH-1:0] bSh;
  logic [WIDTH-1:0] resSh;
  logic [WIDTH-1:0] sumQ;
  logic             carryQ;
  logic             carryOutQ;
  logic             busyQ;
  logic             doneQ;
  logic [CNT_W-1:0] bitCnt;

  logic             sBit;
  logic             cNext;
  logic [WIDTH-1:0] resNext;

  assign sBit    = aSh[0] ^ bSh[0] ^ carryQ;
  assign cNext   = (aSh[0] & bSh[0]) | (carryQ & (aSh[0] ^ bSh[0]));
  assign resNext = {sBit, resSh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      aSh       <= '0;
      bSh       <= '0;
      resSh     <= '0;
      sumQ      <= '0;
      carryQ    <= 1'b0;
      carryOutQ <= 1'b0;
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
      bitCnt    <= '0;
    end else begin
      case (state)
        RUN: begin
          aSh    <= aSh >> 1;
          bSh    <= bSh >> 1;
          resSh  <= resNext;
          carryQ <= cNext;
          bitCnt <= bitCnt + 1'b1;
          // Last bit: publish the whole word at once so sum never shows partial results.
          if (bitCnt == CNT_W'(WIDTH - 1)) begin
            sumQ      <= resNext;
            carryOutQ <= cNext;
            busyQ     <= 1'b0;
            doneQ     <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          doneQ <= 1'b0;
          if (bus.start) begin
            aSh    <= bus.a;
            bSh    <= bus.b;
            carryQ <= bus.carry_in;
            resSh  <= '0;
            bitCnt <= '0;
            busyQ  <= 1'b1;
            state  <= RUN;
          end else begin
            busyQ <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy      = busyQ;
  assign bus.done      = doneQ;
  assign bus.sum       = sumQ;
  assign bus.carry_out = carryOutQ;
endmodule
